axis_rr_packet_arbiter: RTL and testbench

- Shares one registered AXI-Stream output channel between NUM_IN AXI-Stream requesters.
- Uses packet-level round-robin arbitration: a grant is held until the granted input's last beat is accepted.
- Sits in front of the team's AXIS register slice / downstream sink, so multiple producers can use one stream path.
- Output is fully registered, with the same data/valid/last field set as the existing slice, plus a source ID.

---
 rtl/axis_rr_packet_arbiter.sv | 146 ++++++++++++++
 tb/tb_axis_rr_packet_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin arbiter: NUM_IN AXI-Stream inputs share one registered output.
// Optional per-input completed-packet counters are enabled with `define AXIS_ARB_PKT_CNT_EN.
module axis_rr_packet_arbiter #(
  parameter int DW     = 32,
  parameter int NUM_IN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IN*DW-1:0]   s_axis_data,
  input  logic [NUM_IN-1:0]      s_axis_valid,
  input  logic [NUM_IN-1:0]      s_axis_last,
  output logic [NUM_IN-1:0]      s_axis_ready,
  output logic [DW-1:0]          m_axis_data,
  output logic                   m_axis_valid,
  output logic                   m_axis_last,
  output logic [$clog2(NUM_IN)-1:0] m_axis_id,
  input  logic                   m_axis_ready
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_IN*16-1:0]   pkt_cnt
`endif
);

  localparam int IDW = $clog2(NUM_IN);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] rrPtr_q;
  logic [IDW-1:0] gnt_q;
  logic [DW-1:0]  outData_q;
  logic           outValid_q;
  logic           outLast_q;
  logic [IDW-1:0] outId_q;

  logic [DW-1:0]  inData [NUM_IN];
  logic [IDW-1:0] gnt_d;
  logic [IDW-1:0] rrPtr_d;
  logic [IDW:0]   candSum;
  logic [IDW-1:0] cand;
  logic           found;
  logic           slotFree;
  logic           accept;
  logic           acceptLast;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign inData[i] = s_axis_data[i*DW +: DW];
  end

  // First requester at or after the round-robin pointer, wrapping modulo NUM_IN.
  always_comb begin
    gnt_d   = rrPtr_q;
    found   = 1'b0;
    candSum = '0;
    cand    = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      candSum = {1'b0, rrPtr_q} + (IDW+1)'(k);
      if (candSum >= (IDW+1)'(NUM_IN)) begin
        candSum = candSum - (IDW+1)'(NUM_IN);
      end
      cand = candSum[IDW-1:0];
      if (!found && s_axis_valid[cand]) begin
        found = 1'b1;
        gnt_d = cand;
      end
    end
  end

  assign slotFree   = m_axis_ready | ~outValid_q;
  assign accept     = (state_q == BUSY) && s_axis_valid[gnt_q] && slotFree;
  assign acceptLast = accept && s_axis_last[gnt_q];
  assign rrPtr_d    = (gnt_q == IDW'(NUM_IN - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    s_axis_ready = '0;
    if (state_q == BUSY) begin
      s_axis_ready[gnt_q] = slotFree;
    end
  end

  // Arbitration FSM and output register; a load in the same cycle as a drain keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      gnt_q      <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outId_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|s_axis_valid) begin
            gnt_q   <= gnt_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (acceptLast) begin
            state_q <= IDLE;
            rrPtr_q <= rrPtr_d;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        outData_q  <= inData[gnt_q];
        outLast_q  <= s_axis_last[gnt_q];
        outId_q    <= gnt_q;
        outValid_q <= 1'b1;
      end else if (outValid_q && m_axis_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign m_axis_data  = outData_q;
  assign m_axis_valid = outValid_q;
  assign m_axis_last  = outLast_q;
  assign m_axis_id    = outId_q;

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [15:0] pktCnt_q [NUM_IN];

  // Counts packets whose last beat was accepted; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_IN; i++) begin
        pktCnt_q[i] <= '0;
      end
    end else if (acceptLast) begin
      pktCnt_q[gnt_q] <= pktCnt_q[gnt_q] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
    assign pkt_cnt[i*16 +: 16] = pktCnt_q[i];
  end
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for axis_rr_packet_arbiter: cycle vector table plus multi-cycle stream sequences.
// Build with +define+AXIS_ARB_PKT_CNT_EN to also exercise the packet counters.
module tb_axis_rr_packet_arbiter;

  localparam int DW     = 32;
  localparam int NUM_IN = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_IN*DW-1:0] sData;
  logic [NUM_IN-1:0]    sValid;
  logic [NUM_IN-1:0]    sLast;
  logic [NUM_IN-1:0]    sReady;
  logic [DW-1:0]        mData;
  logic                 mValid;
  logic                 mLast;
  logic [1:0]           mId;
  logic                 mReady;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NUM_IN*16-1:0] pktCnt;
`endif

  axis_rr_packet_arbiter #(.DW(DW), .NUM_IN(NUM_IN)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_data  (sData),
    .s_axis_valid (sValid),
    .s_axis_last  (sLast),
    .s_axis_ready (sReady),
    .m_axis_data  (mData),
    .m_axis_valid (mValid),
    .m_axis_last  (mLast),
    .m_axis_id    (mId),
    .m_axis_ready (mReady)
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    .pkt_cnt      (pktCnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        rdy;
    logic        expValid;
    logic        expLast;
    logic [1:0]  expId;
    logic [31:0] expData;
    logic [3:0]  expSReady;
  } vec_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  vec_t  vecs [14];
  beat_t obsQ [$];
  beat_t expQ [$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs (same data on every input) and returns 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] v, input logic [3:0] l,
                               input logic [31:0] d, input logic rdy);
    reset  = rst;
    sValid = v;
    sLast  = l;
    mReady = rdy;
    for (int i = 0; i < NUM_IN; i++) sData[i*DW +: DW] = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beatData(input int id, input int pkt, input int beat);
    return {8'(id), 8'(pkt), 16'(beat)};
  endfunction

  task automatic pushExp(input int id, input int pkt, input int beats);
    beat_t e;
    for (int b = 0; b < beats; b++) begin
      e.id   = 2'(id);
      e.data = beatData(id, pkt, b);
      e.last = (b == beats - 1);
      expQ.push_back(e);
    end
  endtask

  // Each active input sends nPkts packets of the given length; downstream stalls in a cycle window.
  task automatic runStreams(input logic [3:0] active, input int nPkts, input int beats,
                            input int stallStart, input int stallLen, input int maxCycles,
                            input string tag);
    int    pktIdx [NUM_IN];
    int    beatIdx [NUM_IN];
    logic [3:0] acc;
    beat_t prev;
    beat_t cur;
    logic  prevStall;
    int    n;
    obsQ.delete();
    prevStall = 1'b0;
    prev      = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pktIdx[i]  = 0;
      beatIdx[i] = 0;
    end
    reset = 1'b0;
    for (int c = 0; c < maxCycles && obsQ.size() < expQ.size(); c++) begin
      mReady = !(c >= stallStart && c < stallStart + stallLen);
      for (int i = 0; i < NUM_IN; i++) begin
        sValid[i]          = active[i] && (pktIdx[i] < nPkts);
        sLast[i]           = (beatIdx[i] == beats - 1);
        sData[i*DW +: DW]  = beatData(i, pktIdx[i], beatIdx[i]);
      end
      @(negedge clk);
      cur.id   = mId;
      cur.data = mData;
      cur.last = mLast;
      if (prevStall) begin
        checkOutput({tag, " stall hold valid"}, 64'(mValid), 64'd1);
        checkOutput({tag, " stall hold beat"}, 64'(cur), 64'(prev));
      end
      if (mValid && !mReady) begin
        checkOutput({tag, " stall s_ready"}, 64'(sReady), 64'd0);
      end
      prevStall = mValid && !mReady;
      prev      = cur;
      if (mValid && mReady) obsQ.push_back(cur);
      acc = sValid & sReady;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (acc[i]) begin
          if (beatIdx[i] == beats - 1) begin
            beatIdx[i] = 0;
            pktIdx[i]++;
          end else begin
            beatIdx[i]++;
          end
        end
      end
    end
    sValid = '0;
    sLast  = '0;
    mReady = 1'b1;
    checkOutput({tag, " beat count"}, 64'(obsQ.size()), 64'(expQ.size()));
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s beat%0d id", tag, k), 64'(obsQ[k].id), 64'(expQ[k].id));
      checkOutput($sformatf("%s beat%0d data", tag, k), 64'(obsQ[k].data), 64'(expQ[k].data));
      checkOutput($sformatf("%s beat%0d last", tag, k), 64'(obsQ[k].last), 64'(expQ[k].last));
    end
  endtask

  initial begin
    reset  = 1'b1;
    sValid = '0;
    sLast  = '0;
    sData  = '0;
    mReady = 1'b1;

    // Reset hold, single 4-beat packet on input 2, then wrap/skip from rr_ptr=3 over inputs 1 and 3.
    vecs[0]  = '{1'b1, 4'hF, 4'h0, 32'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0};
    vecs[1]  = '{1'b1, 4'hF, 4'h0, 32'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0};
    vecs[2]  = '{1'b1, 4'hF, 4'h0, 32'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0};
    vecs[3]  = '{1'b0, 4'h4, 4'h0, 32'hA0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h4};
    vecs[4]  = '{1'b0, 4'h4, 4'h0, 32'hA0, 1'b1, 1'b1, 1'b0, 2'd2, 32'hA0, 4'h4};
    vecs[5]  = '{1'b0, 4'h4, 4'h0, 32'hA1, 1'b1, 1'b1, 1'b0, 2'd2, 32'hA1, 4'h4};
    vecs[6]  = '{1'b0, 4'h4, 4'h0, 32'hA2, 1'b1, 1'b1, 1'b0, 2'd2, 32'hA2, 4'h4};
    vecs[7]  = '{1'b0, 4'h4, 4'h4, 32'hA3, 1'b1, 1'b1, 1'b1, 2'd2, 32'hA3, 4'h0};
    vecs[8]  = '{1'b0, 4'h0, 4'h0, 32'h00, 1'b1, 1'b0, 1'b1, 2'd2, 32'hA3, 4'h0};
    vecs[9]  = '{1'b0, 4'hA, 4'hA, 32'hB0, 1'b1, 1'b0, 1'b1, 2'd2, 32'hA3, 4'h8};
    vecs[10] = '{1'b0, 4'hA, 4'hA, 32'hB0, 1'b1, 1'b1, 1'b1, 2'd3, 32'hB0, 4'h0};
    vecs[11] = '{1'b0, 4'h2, 4'h2, 32'hB1, 1'b1, 1'b0, 1'b1, 2'd3, 32'hB0, 4'h2};
    vecs[12] = '{1'b0, 4'h2, 4'h2, 32'hB1, 1'b1, 1'b1, 1'b1, 2'd1, 32'hB1, 4'h0};
    vecs[13] = '{1'b0, 4'h0, 4'h0, 32'h00, 1'b1, 1'b0, 1'b1, 2'd1, 32'hB1, 4'h0};

    for (int k = 0; k < 14; k++) begin
      applyStimulus(vecs[k].rst, vecs[k].valid, vecs[k].last, vecs[k].data, vecs[k].rdy);
      checkOutput($sformatf("vec%0d m_valid", k), 64'(mValid), 64'(vecs[k].expValid));
      checkOutput($sformatf("vec%0d m_last", k), 64'(mLast), 64'(vecs[k].expLast));
      checkOutput($sformatf("vec%0d m_id", k), 64'(mId), 64'(vecs[k].expId));
      checkOutput($sformatf("vec%0d m_data", k), 64'(mData), 64'(vecs[k].expData));
      checkOutput($sformatf("vec%0d s_ready", k), 64'(sReady), 64'(vecs[k].expSReady));
    end

    // Reset mid-packet: move rr_ptr to 3, abandon a packet from input 0, then 0 must win over 3.
    applyStimulus(1'b0, 4'h4, 4'h4, 32'hC0, 1'b1);
    applyStimulus(1'b0, 4'h4, 4'h4, 32'hC0, 1'b1);
    checkOutput("rst seq C0 id", 64'(mId), 64'd2);
    applyStimulus(1'b0, 4'h1, 4'h0, 32'hD0, 1'b1);
    applyStimulus(1'b0, 4'h1, 4'h0, 32'hD0, 1'b1);
    applyStimulus(1'b0, 4'h1, 4'h0, 32'hD1, 1'b1);
    checkOutput("rst seq D1 data", 64'(mData), 64'hD1);
    checkOutput("rst seq D1 id", 64'(mId), 64'd0);
    applyStimulus(1'b1, 4'h1, 4'h0, 32'hD2, 1'b1);
    checkOutput("rst seq m_valid", 64'(mValid), 64'd0);
    checkOutput("rst seq m_data", 64'(mData), 64'd0);
    checkOutput("rst seq s_ready", 64'(sReady), 64'd0);
    applyStimulus(1'b0, 4'h9, 4'h9, 32'hE0, 1'b1);
    checkOutput("rst seq regrant s_ready", 64'(sReady), 64'h1);
    checkOutput("rst seq no stale beat", 64'(mValid), 64'd0);
    applyStimulus(1'b0, 4'h9, 4'h9, 32'hE0, 1'b1);
    checkOutput("rst seq regrant id", 64'(mId), 64'd0);
    checkOutput("rst seq regrant data", 64'(mData), 64'hE0);
    checkOutput("rst seq regrant valid", 64'(mValid), 64'd1);

    // Fairness: every input keeps requesting 2-beat packets.
    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
    expQ.delete();
    for (int r = 0; r < 2; r++) begin
      for (int id = 0; id < NUM_IN; id++) pushExp(id, r, 2);
    end
    runStreams(4'hF, 2, 2, 1000, 0, 300, "rr");

    // Backpressure mid-packet on a 5-beat packet from input 1.
    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
    expQ.delete();
    pushExp(1, 0, 5);
    runStreams(4'h2, 1, 5, 3, 3, 200, "bp");

`ifdef AXIS_ARB_PKT_CNT_EN
    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
    expQ.delete();
    for (int p = 0; p < 3; p++) pushExp(1, p, 2);
    runStreams(4'h2, 3, 2, 1000, 0, 200, "cnt");
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1);
    checkOutput("pkt_cnt[0]", 64'(pktCnt[15:0]), 64'd0);
    checkOutput("pkt_cnt[1]", 64'(pktCnt[31:16]), 64'd3);
    checkOutput("pkt_cnt[2]", 64'(pktCnt[47:32]), 64'd0);
    checkOutput("pkt_cnt[3]", 64'(pktCnt[63:48]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
